voice_alloc: RTL and testbench

Polyphonic voice allocator between the MIDI message parser and the synthesizer voice engine. It accepts note-on/note-off events, maps each to one of NVOICES voice slots, and issues a one-cycle note_pressed or note_released pulse with the slot address, note, velocity and channel. The synthesizer uses these pulses to write its per-voice control RAM. Allocation picks a retrigger slot first, then the lowest free slot, then a round-robin steal.

---
 rtl/voice_alloc_if.sv | 26 ++
 rtl/voice_alloc.sv | 183 ++++++++++++++++++
 tb/tb_voice_alloc.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_alloc_if.sv
// Event and voice-pulse bus between the MIDI parser, the voice allocator and the synth engine.
interface voice_alloc_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_on;
  logic [6:0] in_note;
  logic [6:0] in_velocity;
  logic [3:0] in_channel;
  logic       note_pressed;
  logic       note_released;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic [7:0] addr;
  logic [7:0] active_count;

  modport master (
    output in_valid, in_on, in_note, in_velocity, in_channel,
    input  in_ready, note_pressed, note_released, note, velocity, channel, addr, active_count
  );

  modport slave (
    input  in_valid, in_on, in_note, in_velocity, in_channel,
    output in_ready, note_pressed, note_released, note, velocity, channel, addr, active_count
  );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: retrigger, else lowest free slot, else round-robin steal.
// One slot is scanned per cycle; results are issued as a one-cycle pulse.
module voice_alloc #(
  parameter int unsigned NVOICES = 128
) (
  input  logic          clk32,
  input  logic          rst,
  voice_alloc_if.slave  bus
);

  localparam int unsigned IW = $clog2(NVOICES);
  localparam int unsigned TW = 11;
  localparam logic [IW-1:0] LAST = IW'(NVOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DECIDE, EMIT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             mvld_q, mvld_d, fvld_q, fvld_d;
  logic [IW-1:0]    midx_q, midx_d, fidx_q, fidx_d;
  logic [IW-1:0]    steal_q, steal_d;
  logic [7:0]       count_q, count_d;
  logic             ready_q, ready_d;
  logic             pressed_q, pressed_d, released_q, released_d;
  logic [6:0]       note_q, note_d, vel_q, vel_d;
  logic [3:0]       ch_q, ch_d;
  logic [IW-1:0]    addr_q, addr_d;
  logic             ev_on_q, ev_on_d;
  logic [6:0]       ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
  logic [3:0]       ev_ch_q, ev_ch_d;
  logic             tag_we, act_set, act_clr, hit;
  logic [NVOICES-1:0] active_q;
  logic [TW-1:0]    tag_q [NVOICES];

  // Next-state, scan bookkeeping and allocation decision
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mvld_d     = mvld_q;
    midx_d     = midx_q;
    fvld_d     = fvld_q;
    fidx_d     = fidx_q;
    steal_d    = steal_q;
    count_d    = count_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    note_d     = note_q;
    vel_d      = vel_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    ev_on_d    = ev_on_q;
    ev_note_d  = ev_note_q;
    ev_vel_d   = ev_vel_q;
    ev_ch_d    = ev_ch_q;
    tag_we     = 1'b0;
    act_set    = 1'b0;
    act_clr    = 1'b0;
    hit        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && ready_q) begin
          state_d   = SCAN;
          idx_d     = '0;
          mvld_d    = 1'b0;
          fvld_d    = 1'b0;
          // velocity-0 note-on is a note-off
          ev_on_d   = bus.in_on && (bus.in_velocity != 7'd0);
          ev_note_d = bus.in_note;
          ev_vel_d  = bus.in_velocity;
          ev_ch_d   = bus.in_channel;
        end
      end
      SCAN: begin
        hit = active_q[idx_q] && (tag_q[idx_q] == {ev_note_q, ev_ch_q});
        if (hit && !mvld_q) begin
          mvld_d = 1'b1;
          midx_d = idx_q;
        end
        if (!active_q[idx_q] && !fvld_q) begin
          fvld_d = 1'b1;
          fidx_d = idx_q;
        end
        if (idx_q == LAST) state_d = DECIDE;
        else               idx_d   = idx_q + IW'(1);
      end
      DECIDE: begin
        state_d = IDLE;
        if (ev_on_q || mvld_q) begin
          state_d = EMIT;
          note_d  = ev_note_q;
          vel_d   = ev_vel_q;
          ch_d    = ev_ch_q;
        end
        if (ev_on_q) begin
          pressed_d = 1'b1;
          if (mvld_q) begin
            addr_d = midx_q;
          end else if (fvld_q) begin
            addr_d  = fidx_q;
            tag_we  = 1'b1;
            act_set = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            addr_d  = steal_q;
            tag_we  = 1'b1;
            steal_d = (steal_q == LAST) ? '0 : steal_q + IW'(1);
          end
        end else if (mvld_q) begin
          released_d = 1'b1;
          addr_d     = midx_q;
          act_clr    = 1'b1;
          count_d    = count_q - 8'd1;
        end
      end
      EMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and control registers
  always_ff @(posedge clk32) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mvld_q     <= 1'b0;
      midx_q     <= '0;
      fvld_q     <= 1'b0;
      fidx_q     <= '0;
      steal_q    <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      ev_on_q    <= 1'b0;
      ev_note_q  <= '0;
      ev_vel_q   <= '0;
      ev_ch_q    <= '0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mvld_q     <= mvld_d;
      midx_q     <= midx_d;
      fvld_q     <= fvld_d;
      fidx_q     <= fidx_d;
      steal_q    <= steal_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      ch_q       <= ch_d;
      addr_q     <= addr_d;
      ev_on_q    <= ev_on_d;
      ev_note_q  <= ev_note_d;
      ev_vel_q   <= ev_vel_d;
      ev_ch_q    <= ev_ch_d;
      if (act_set) active_q[addr_d] <= 1'b1;
      if (act_clr) active_q[addr_d] <= 1'b0;
    end
  end

  // Tag table is not reset; an inactive slot's tag is never compared
  always_ff @(posedge clk32) begin
    if (!rst && tag_we) tag_q[addr_d] <= {ev_note_q, ev_ch_q};
  end

  assign bus.in_ready      = ready_q;
  assign bus.note_pressed  = pressed_q;
  assign bus.note_released = released_q;
  assign bus.note          = note_q;
  assign bus.velocity      = vel_q;
  assign bus.channel       = ch_q;
  assign bus.addr          = 8'(addr_q);
  assign bus.active_count  = count_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios on a 128-voice and a 4-voice instance,
// plus random event streams checked against a slot-table reference model.
module tb_voice_alloc;
  localparam int unsigned NB = 128;
  localparam int unsigned NS = 4;

  logic clk32 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk32 = ~clk32;

  voice_alloc_if bb ();
  voice_alloc_if sb ();

  voice_alloc #(.NVOICES(NB)) dut_b (.clk32(clk32), .rst(rst), .bus(bb.slave));
  voice_alloc #(.NVOICES(NS)) dut_s (.clk32(clk32), .rst(rst), .bus(sb.slave));

  int tests = 0;
  int fails = 0;
  bit sel = 1'b0;
  int unsigned nv = NB;

  logic       o_ready, o_pressed, o_released;
  logic [6:0] o_note, o_vel;
  logic [3:0] o_ch;
  logic [7:0] o_addr, o_count;
  assign o_ready    = sel ? sb.in_ready      : bb.in_ready;
  assign o_pressed  = sel ? sb.note_pressed  : bb.note_pressed;
  assign o_released = sel ? sb.note_released : bb.note_released;
  assign o_note     = sel ? sb.note          : bb.note;
  assign o_vel      = sel ? sb.velocity      : bb.velocity;
  assign o_ch       = sel ? sb.channel       : bb.channel;
  assign o_addr     = sel ? sb.addr          : bb.addr;
  assign o_count    = sel ? sb.active_count  : bb.active_count;

  typedef struct {
    int kind; int pcyc; int plen; int rcyc; int both;
    int addr; int note; int vel; int ch;
    int count; int haddr; int hnote; int hvel; int hch;
  } obs_t;

  // Reference model: plain slot table
  bit       m_act [NB];
  int       m_note [NB];
  int       m_ch [NB];
  int       m_steal, m_count;
  int       m_oaddr, m_onote, m_ovel, m_och;

  task automatic model_reset(input int unsigned n);
    nv = n;
    for (int i = 0; i < int'(NB); i++) m_act[i] = 1'b0;
    m_steal = 0; m_count = 0;
    m_oaddr = 0; m_onote = 0; m_ovel = 0; m_och = 0;
  endtask

  task automatic model_event(input bit on, input int n, input int v, input int c,
                             output int kind, output int a);
    int m = -1;
    int f = -1;
    for (int i = 0; i < int'(nv); i++) begin
      if (m < 0 && m_act[i] && m_note[i] == n && m_ch[i] == c) m = i;
      if (f < 0 && !m_act[i]) f = i;
    end
    kind = 0; a = -1;
    if (on && v != 0) begin
      kind = 1;
      if (m >= 0) a = m;
      else if (f >= 0) begin
        a = f; m_act[f] = 1'b1; m_note[f] = n; m_ch[f] = c; m_count++;
      end else begin
        a = m_steal; m_note[a] = n; m_ch[a] = c; m_steal = (m_steal + 1) % int'(nv);
      end
    end else if (m >= 0) begin
      kind = 2; a = m; m_act[m] = 1'b0; m_count--;
    end
    if (kind != 0) begin
      m_oaddr = a; m_onote = n; m_ovel = v; m_och = c;
    end
  endtask

  task automatic drive_idle();
    bb.in_valid = 1'b0; bb.in_on = 1'b0; bb.in_note = '0; bb.in_velocity = '0; bb.in_channel = '0;
    sb.in_valid = 1'b0; sb.in_on = 1'b0; sb.in_note = '0; sb.in_velocity = '0; sb.in_channel = '0;
  endtask

  task automatic do_reset();
    @(negedge clk32);
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk32);
    rst = 1'b0;
    @(negedge clk32);
    model_reset(sel ? NS : NB);
  endtask

  task automatic accept(input bit on, input int n, input int v, input int c, output bit ok);
    for (int i = 0; i < 300 && !o_ready; i++) @(negedge clk32);
    ok = o_ready;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stayed %0b, want 1", o_ready);
      return;
    end
    if (sel) begin
      sb.in_on = on; sb.in_note = 7'(n); sb.in_velocity = 7'(v); sb.in_channel = 4'(c); sb.in_valid = 1'b1;
    end else begin
      bb.in_on = on; bb.in_note = 7'(n); bb.in_velocity = 7'(v); bb.in_channel = 4'(c); bb.in_valid = 1'b1;
    end
    @(posedge clk32);
    @(negedge clk32);
    bb.in_valid = 1'b0;
    sb.in_valid = 1'b0;
  endtask

  // Sends one event and records what the DUT did, cycle numbers counted from acceptance
  task automatic do_event(input bit on, input int n, input int v, input int c, output obs_t o);
    bit ok;
    o = '{default: 0};
    o.pcyc = -1; o.rcyc = -1; o.addr = -1;
    accept(on, n, v, c, ok);
    if (!ok) return;
    for (int cyc = 1; cyc <= int'(nv) + 10; cyc++) begin
      if (o_pressed && o_released) o.both++;
      if (o_pressed || o_released) begin
        o.plen++;
        if (o.pcyc < 0) begin
          o.pcyc = cyc; o.kind = o_pressed ? 1 : 2; o.addr = int'(o_addr);
          o.note = int'(o_note); o.vel = int'(o_vel); o.ch = int'(o_ch);
        end
      end
      if (o_ready) begin
        o.rcyc = cyc;
        break;
      end
      @(negedge clk32);
    end
    if (o.rcyc < 0) begin
      tests++; fails++;
      $display("FAIL ready_return_timeout: in_ready never returned, want within %0d cycles", nv + 10);
    end
    o.count = int'(o_count); o.haddr = int'(o_addr); o.hnote = int'(o_note);
    o.hvel = int'(o_vel); o.hch = int'(o_ch);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(negedge clk32);
    rst = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk32);
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b want 0", o_ready); end
    tests++; if ({o_pressed, o_released} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b want 00", {o_pressed, o_released}); end
    tests++; if ({o_note, o_vel, o_ch, o_addr} !== 26'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", {o_note, o_vel, o_ch, o_addr}); end
    tests++; if (o_count !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_count); end
    rst = 1'b0;
    @(negedge clk32);
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %0b want 1", o_ready); end
    sel = 1'b1;
    tests++; if (o_ready !== 1'b1 || o_count !== 8'd0) begin fails++; $display("FAIL reset_small: ready %0b count %0d want 1 0", o_ready, o_count); end
    sel = 1'b0;
  endtask

  task automatic test_first_note();
    obs_t o;
    sel = 1'b0; do_reset();
    do_event(1'b1, 60, 100, 0, o);
    tests++; if (o.kind != 1 || o.pcyc != 130 || o.plen != 1) begin fails++; $display("FAIL first_pulse: kind %0d cyc %0d len %0d want 1 130 1", o.kind, o.pcyc, o.plen); end
    tests++; if (o.addr != 0 || o.note != 60 || o.vel != 100 || o.ch != 0) begin fails++; $display("FAIL first_fields: addr %0d note %0d vel %0d ch %0d want 0 60 100 0", o.addr, o.note, o.vel, o.ch); end
    tests++; if (o.count != 1 || o.rcyc != 131) begin fails++; $display("FAIL first_count_ready: count %0d ready %0d want 1 131", o.count, o.rcyc); end
  endtask

  task automatic test_release();
    obs_t o;
    sel = 1'b0; do_reset();
    do_event(1'b1, 60, 90, 0, o);
    do_event(1'b1, 64, 90, 0, o);
    tests++; if (o.addr != 1) begin fails++; $display("FAIL release_second_addr: got %0d want 1", o.addr); end
    do_event(1'b0, 60, 33, 0, o);
    tests++; if (o.kind != 2 || o.addr != 0 || o.vel != 33 || o.count != 1) begin fails++; $display("FAIL release_off: kind %0d addr %0d vel %0d count %0d want 2 0 33 1", o.kind, o.addr, o.vel, o.count); end
    do_event(1'b1, 67, 80, 0, o);
    tests++; if (o.kind != 1 || o.addr != 0 || o.count != 2) begin fails++; $display("FAIL release_reuse: kind %0d addr %0d count %0d want 1 0 2", o.kind, o.addr, o.count); end
  endtask

  task automatic test_retrigger();
    obs_t o;
    sel = 1'b0; do_reset();
    do_event(1'b1, 60, 50, 3, o);
    do_event(1'b1, 60, 70, 3, o);
    tests++; if (o.kind != 1 || o.addr != 0 || o.count != 1 || o.vel != 70) begin fails++; $display("FAIL retrigger: kind %0d addr %0d count %0d vel %0d want 1 0 1 70", o.kind, o.addr, o.count, o.vel); end
    do_event(1'b1, 60, 70, 4, o);
    tests++; if (o.addr != 1 || o.ch != 4 || o.count != 2) begin fails++; $display("FAIL retrigger_other_ch: addr %0d ch %0d count %0d want 1 4 2", o.addr, o.ch, o.count); end
  endtask

  task automatic test_vel0_and_drop();
    obs_t o;
    sel = 1'b0; do_reset();
    for (int i = 0; i < 6; i++) do_event(1'b1, 67 + i, 64, 0, o);
    tests++; if (o.addr != 5 || o.count != 6) begin fails++; $display("FAIL fill_six: addr %0d count %0d want 5 6", o.addr, o.count); end
    do_event(1'b1, 72, 0, 0, o);
    tests++; if (o.kind != 2 || o.addr != 5 || o.vel != 0 || o.count != 5) begin fails++; $display("FAIL vel0_release: kind %0d addr %0d vel %0d count %0d want 2 5 0 5", o.kind, o.addr, o.vel, o.count); end
    do_event(1'b0, 50, 40, 0, o);
    tests++; if (o.plen != 0 || o.rcyc != 130 || o.count != 5) begin fails++; $display("FAIL drop: pulses %0d ready %0d count %0d want 0 130 5", o.plen, o.rcyc, o.count); end
    tests++; if (o.haddr != 5 || o.hnote != 72 || o.hvel != 0) begin fails++; $display("FAIL drop_hold: addr %0d note %0d vel %0d want 5 72 0", o.haddr, o.hnote, o.hvel); end
  endtask

  task automatic test_steal();
    obs_t o;
    int exp_addr [5] = '{0, 1, 2, 3, 0};
    sel = 1'b1; do_reset();
    for (int i = 0; i < 4; i++) begin
      do_event(1'b1, 60 + i, 100, 0, o);
      tests++; if (o.addr != i || o.pcyc != 6) begin fails++; $display("FAIL steal_fill_%0d: addr %0d cyc %0d want %0d 6", i, o.addr, o.pcyc, i); end
    end
    for (int i = 0; i < 5; i++) begin
      do_event(1'b1, 70 + i, 100, 0, o);
      tests++; if (o.kind != 1 || o.addr != exp_addr[i] || o.count != 4) begin fails++; $display("FAIL steal_%0d: kind %0d addr %0d count %0d want 1 %0d 4", i, o.kind, o.addr, o.count, exp_addr[i]); end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    obs_t o;
    bit ok;
    int pulses = 0;
    sel = 1'b0; do_reset();
    do_event(1'b1, 60, 100, 0, o);
    accept(1'b1, 61, 100, 0, ok);
    repeat (20) @(negedge clk32);
    rst = 1'b1;
    @(negedge clk32);
    rst = 1'b0;
    for (int i = 0; i < int'(NB) + 5; i++) begin
      if (o_pressed || o_released) pulses++;
      @(negedge clk32);
    end
    model_reset(NB);
    tests++; if (pulses != 0 || o_count !== 8'd0 || o_ready !== 1'b1) begin fails++; $display("FAIL mid_scan_reset: pulses %0d count %0d ready %0b want 0 0 1", pulses, o_count, o_ready); end
    do_event(1'b1, 65, 20, 2, o);
    tests++; if (o.addr != 0 || o.count != 1) begin fails++; $display("FAIL after_reset_note: addr %0d count %0d want 0 1", o.addr, o.count); end
  endtask

  task automatic test_random(input bit s, input int nev);
    obs_t o;
    int ek, ea;
    sel = s; do_reset();
    for (int e = 0; e < nev; e++) begin
      bit on = ($urandom_range(0, 2) != 0);
      int n = 60 + int'($urandom_range(0, 5));
      int c = int'($urandom_range(0, 1));
      int v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      model_event(on, n, v, c, ek, ea);
      do_event(on, n, v, c, o);
      tests++;
      if (o.kind != ek || (ek != 0 && o.addr != ea)) begin
        fails++; $display("FAIL rand_%0d_pulse: kind %0d addr %0d want %0d %0d", e, o.kind, o.addr, ek, ea);
      end
      tests++;
      if (o.pcyc != ((ek != 0) ? int'(nv) + 2 : -1) || o.plen != ((ek != 0) ? 1 : 0) || o.both != 0 ||
          o.rcyc != ((ek != 0) ? int'(nv) + 3 : int'(nv) + 2)) begin
        fails++; $display("FAIL rand_%0d_timing: pulse %0d len %0d both %0d ready %0d want %0d %0d 0 %0d", e, o.pcyc, o.plen, o.both, o.rcyc,
                          (ek != 0) ? int'(nv) + 2 : -1, (ek != 0) ? 1 : 0, (ek != 0) ? int'(nv) + 3 : int'(nv) + 2);
      end
      tests++;
      if (o.count != m_count || o.haddr != m_oaddr || o.hnote != m_onote || o.hvel != m_ovel || o.hch != m_och) begin
        fails++; $display("FAIL rand_%0d_state: count %0d addr %0d note %0d vel %0d ch %0d want %0d %0d %0d %0d %0d", e,
                          o.count, o.haddr, o.hnote, o.hvel, o.hch, m_count, m_oaddr, m_onote, m_ovel, m_och);
      end
    end
    sel = 1'b0;
  endtask

  initial begin
    drive_idle();
    repeat (2) @(negedge clk32);
    test_reset();
    test_first_note();
    test_release();
    test_retrigger();
    test_vel0_and_drop();
    test_steal();
    test_reset_mid_scan();
    test_random(1'b1, 300);
    test_random(1'b0, 12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
